// File: rtl/apb_rr_master.sv
// apb_rr_master
//   Round-robin APB master. It shares one APB completer between NUM_REQ
//   requesters. Each requester has a valid/ready request channel and gets a
//   one-cycle rsp_valid pulse when its transfer finishes. If the completer
//   does not assert PREADY within TIMEOUT_CYCLES ACCESS cycles, the transfer
//   is aborted and the response carries rsp_err=1.
//
// Ports
//   PCLK, PRESETn        clock (rising edge) and async active-low reset
//   req_valid/req_ready  per-requester handshake; at most one ready bit is set
//   req_write            per requester: 1 = write, 0 = read
//   req_addr, req_wdata  packed per requester; requester i at [i*W +: W]
//   rsp_valid            one-cycle completion pulse to the owning requester
//   rsp_rdata, rsp_err   shared read data and timeout flag; valid with rsp_valid
//   PSEL .. PREADY       APB completer interface
//   busy                 high while a transfer is in SETUP or ACCESS
//
// state  | meaning
// IDLE   | arbitrate; accept one request and launch SETUP
// SETUP  | PSEL=1, PENABLE=0, held for exactly one cycle
// ACCESS | PSEL=1, PENABLE=1; wait for PREADY or timeout

module apb_rr_master #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  input  logic [DATA_WIDTH-1:0]            PRDATA,
  input  logic                             PREADY,
  output logic                             busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [PTR_W-1:0] LAST_REQ  = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_found;
  logic [PTR_W:0]   cand;
  logic [CNT_W-1:0] wait_cnt;

  // Search ptr, ptr+1, ... (mod NUM_REQ). One extra bit on cand lets the
  // wrap be a single subtract, which also works when NUM_REQ is not a power of 2.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_REQ)) cand = cand - (PTR_W+1)'(NUM_REQ);
      if (!grant_found && req_valid[cand[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_found) req_ready[grant_idx] = 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      wait_cnt  <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      // The response is a single-cycle pulse; the fields are zero outside it.
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_found) begin
            PADDR   <= req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            PWDATA  <= req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            PWRITE  <= req_write[grant_idx];
            owner   <= grant_idx;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          // PREADY takes priority, so a completer that answers on the last
          // allowed cycle still completes normally.
          if (PREADY || wait_cnt == WAIT_LAST) begin
            PSEL             <= 1'b0;
            PENABLE          <= 1'b0;
            state            <= IDLE;
            rsp_valid[owner] <= 1'b1;
            rsp_err          <= !PREADY;
            rsp_rdata        <= (PREADY && !PWRITE) ? PRDATA : '0;
            ptr              <= (owner == LAST_REQ) ? '0 : owner + 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// Testbench for apb_rr_master.
// A memory-backed APB completer is modelled with random wait states.
// Addresses with bit 31 set are never acknowledged, so those transfers
// must time out. Expected responses are queued per requester when a request
// is issued. A monitor pops them when rsp_valid appears and also checks
// arbitration order, APB phase sequencing and response timing.

module tb_apb_rr_master;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 16;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  logic              PCLK = 1'b0;
  logic              PRESETn = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      req_write = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*DW-1:0]   req_wdata = '0;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              PSEL, PENABLE, PWRITE;
  logic [AW-1:0]     PADDR;
  logic [DW-1:0]     PWDATA;
  logic [DW-1:0]     PRDATA = '0;
  logic              PREADY = 1'b0;
  logic              busy;

  apb_rr_master #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .busy(busy)
  );

  initial forever #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  exp_t          exp_q[N][$];
  logic [DW-1:0] ref_mem[logic [AW-1:0]];
  logic [DW-1:0] mem[logic [AW-1:0]];
  int            grant_log[$];
  logic [AW-1:0] paddr_log[$];
  int            force_wait = -1;
  int            last_acc_len = 0;
  int            last_busy_len = 0;
  int            rsp_count = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic int rr_pick(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int first_set(logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int k = 0; k < N; k++) if (exp_q[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- APB completer: memory with wait states -----------------
  int c_cnt = 0;
  int c_wait = 0;
  initial forever begin
    @(posedge PCLK);
    #1;
    if (PSEL && PENABLE) begin
      c_cnt++;
      if (!PADDR[AW-1] && c_cnt > c_wait) begin
        PREADY = 1'b1;
        if (PWRITE) begin
          mem[PADDR] = PWDATA;
          PRDATA = $urandom;
        end else begin
          PRDATA = mem.exists(PADDR) ? mem[PADDR] : '0;
        end
      end else begin
        PREADY = 1'b0;
        PRDATA = $urandom;
      end
    end else begin
      c_cnt  = 0;
      PREADY = 1'($urandom_range(0, 1));
      PRDATA = $urandom;
      if (force_wait >= 0) c_wait = force_wait;
      else if ($urandom_range(0, 7) == 0) c_wait = $urandom_range(0, 15);
      else c_wait = $urandom_range(0, 2);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int            m_state = 0;   // 0 idle, 1 setup, 2 access
  int            m_ptr = 0;
  int            m_owner = 0;
  int            m_cnt = 0;
  int            m_g;
  bit            m_expect_rsp = 1'b0;
  bit            m_expect_err = 1'b0;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_write;
  int            busy_run = 0;
  exp_t          m_e;

  initial forever begin
    @(negedge PCLK);
    if (!PRESETn) begin
      m_state = 0; m_ptr = 0; m_expect_rsp = 1'b0; busy_run = 0;
    end else begin
      if (|rsp_valid) rsp_count++;
      if (busy) busy_run++;
      else if (busy_run != 0) begin last_busy_len = busy_run; busy_run = 0; end

      if (m_expect_rsp) begin
        chk("rsp_valid", 64'(rsp_valid), 64'(N'(1) << m_owner));
        chk("rsp_err_timing", 64'(rsp_err), 64'(m_expect_err));
        if (exp_q[m_owner].size() == 0) begin
          chk("rsp_unexpected", 64'(1), 64'(0));
        end else begin
          m_e = exp_q[m_owner].pop_front();
          chk("rsp_rdata", 64'(rsp_rdata), 64'(m_e.rdata));
          chk("rsp_err", 64'(rsp_err), 64'(m_e.err));
        end
        m_ptr = (m_owner + 1) % N;
        m_expect_rsp = 1'b0;
      end else begin
        chk("rsp_quiet", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
      end

      chk("busy", 64'(busy), 64'(m_state != 0));

      case (m_state)
        0: begin
          chk("idle_apb", 64'({PSEL, PENABLE}), 64'(0));
          m_g = rr_pick(req_valid, m_ptr);
          if (m_g >= 0) begin
            chk("grant", 64'(req_ready), 64'(N'(1) << m_g));
            grant_log.push_back(first_set(req_ready));
            m_owner = m_g;
            m_addr  = req_addr[m_g*AW +: AW];
            m_wdata = req_wdata[m_g*DW +: DW];
            m_write = req_write[m_g];
            m_state = 1;
          end else begin
            chk("ready_idle", 64'(req_ready), 64'(0));
          end
        end
        1: begin
          chk("setup_apb", 64'({PSEL, PENABLE}), 64'(2'b10));
          chk("setup_addr", 64'(PADDR), 64'(m_addr));
          chk("setup_wr_data", 64'({PWRITE, PWDATA}), 64'({m_write, m_wdata}));
          chk("ready_busy", 64'(req_ready), 64'(0));
          paddr_log.push_back(PADDR);
          m_state = 2;
          m_cnt = 0;
        end
        default: begin
          chk("access_apb", 64'({PSEL, PENABLE}), 64'(2'b11));
          chk("access_addr", 64'(PADDR), 64'(m_addr));
          chk("access_wr_data", 64'({PWRITE, PWDATA}), 64'({m_write, m_wdata}));
          chk("ready_busy", 64'(req_ready), 64'(0));
          if (PREADY) begin
            m_expect_rsp = 1'b1; m_expect_err = 1'b0;
            last_acc_len = m_cnt + 1; m_state = 0;
          end else if (m_cnt == T - 1) begin
            m_expect_rsp = 1'b1; m_expect_err = 1'b1;
            last_acc_len = T; m_state = 0;
          end else begin
            m_cnt++;
          end
        end
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(int i, bit w, logic [AW-1:0] a, logic [DW-1:0] d);
    exp_t e;
    req_valid[i] = 1'b1;
    req_write[i] = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    e.err = a[AW-1];
    if (w) begin
      e.rdata = '0;
      if (!a[AW-1]) ref_mem[a] = d;
    end else begin
      e.rdata = (!a[AW-1] && ref_mem.exists(a)) ? ref_mem[a] : '0;
    end
    exp_q[i].push_back(e);
  endtask

  task automatic tick();
    logic [N-1:0] acc;
    @(negedge PCLK);
    acc = req_valid & req_ready;
    @(posedge PCLK);
    #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic drain(string name);
    int c = 0;
    while (!all_empty() && c < 300) begin tick(); c++; end
    chk(name, 64'(all_empty()), 64'(1));
    if (!all_empty()) for (int k = 0; k < N; k++) exp_q[k].delete();
    req_valid = '0;
  endtask

  task automatic do_reset();
    req_valid = '0;
    @(posedge PCLK); #1;
    PRESETn = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    for (int k = 0; k < N; k++) exp_q[k].delete();
  endtask

  int exp_g[5]       = '{0, 1, 2, 3, 0};
  int exp_a[5]       = '{'h0, 'h4, 'h8, 'hC, 'h0};
  int rc0;
  bit reissued;
  logic [AW-1:0] ra;

  initial begin
    repeat (3) @(posedge PCLK);
    #1;
    chk("reset_ctrl", 64'({PSEL, PENABLE, PWRITE, busy, rsp_err, rsp_valid, req_ready}), 64'(0));
    chk("reset_data", 64'({PADDR, PWDATA}), 64'(0));
    chk("reset_rdata", 64'(rsp_rdata), 64'(0));
    PRESETn = 1'b1;

    // single write then read
    force_wait = 0;
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF);
    drain("drain_write");
    issue(0, 1'b0, 32'h10, '0);
    drain("drain_read");

    // round robin with all four continuously valid
    do_reset();
    grant_log.delete(); paddr_log.delete();
    for (int i = 0; i < N; i++) issue(i, 1'b1, AW'(i * 4), $urandom);
    reissued = 1'b0;
    for (int c = 0; c < 300 && !(reissued && all_empty()); c++) begin
      tick();
      if (!reissued && exp_q[0].size() == 0) begin
        issue(0, 1'b1, 32'h0, $urandom);
        reissued = 1'b1;
      end
    end
    drain("drain_rr");
    chk("rr_count", 64'(grant_log.size()), 64'(5));
    for (int k = 0; k < 5 && k < grant_log.size(); k++) chk("rr_grant", 64'(grant_log[k]), 64'(exp_g[k]));
    for (int k = 0; k < 5 && k < paddr_log.size(); k++) chk("rr_paddr", 64'(paddr_log[k]), 64'(exp_a[k]));

    // pointer wrap: serve req 2, then reqs 0 and 3 together
    issue(2, 1'b1, 32'h200, 32'h2222_0000);
    drain("drain_wrap_a");
    grant_log.delete();
    issue(0, 1'b1, 32'h20, 32'h0000_0A0A);
    issue(3, 1'b1, 32'h300, 32'h0303_0303);
    drain("drain_wrap_b");
    chk("wrap_count", 64'(grant_log.size()), 64'(2));
    if (grant_log.size() == 2) begin
      chk("wrap_first", 64'(grant_log[0]), 64'(3));
      chk("wrap_second", 64'(grant_log[1]), 64'(0));
    end

    // timeout, then normal traffic from the same requester
    issue(1, 1'b0, 32'h8000_0100, '0);
    drain("drain_timeout");
    chk("timeout_len", 64'(last_acc_len), 64'(T));
    issue(1, 1'b1, 32'h104, 32'h1234_5678);
    drain("drain_after_to_w");
    issue(1, 1'b0, 32'h104, '0);
    drain("drain_after_to_r");

    // wait states: PREADY on the 3rd ACCESS cycle
    force_wait = 2;
    rc0 = rsp_count;
    issue(2, 1'b1, 32'h208, 32'hCAFE_F00D);
    drain("drain_wait");
    chk("wait_acc_len", 64'(last_acc_len), 64'(3));
    chk("wait_busy_len", 64'(last_busy_len), 64'(4));
    chk("wait_rsp_pulses", 64'(rsp_count - rc0), 64'(1));
    // PREADY on the last allowed ACCESS cycle still completes without error
    force_wait = T - 1;
    issue(2, 1'b0, 32'h208, '0);
    drain("drain_wait_edge");
    chk("edge_acc_len", 64'(last_acc_len), 64'(T));

    // randomized traffic, disjoint address regions per requester
    force_wait = -1;
    for (int c = 0; c < 600; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && exp_q[i].size() == 0 && $urandom_range(0, 2) == 0) begin
          ra = AW'((i << 8) | ($urandom_range(0, 7) << 2));
          if ($urandom_range(0, 11) == 0) ra[AW-1] = 1'b1;
          issue(i, 1'($urandom_range(0, 1)), ra, $urandom);
        end
      end
    end
    drain("drain_random");

    // reset in the middle of ACCESS
    force_wait = 0;
    issue(1, 1'b1, 32'h110, 32'h1111_1111);
    drain("drain_pre_reset");
    issue(0, 1'b0, 32'h8000_0000, '0);
    repeat (3) tick();
    #2;
    PRESETn = 1'b0;
    #1;
    chk("rst_mid_ctrl", 64'({PSEL, PENABLE, PWRITE, busy, rsp_err, rsp_valid}), 64'(0));
    chk("rst_mid_data", 64'({PADDR, PWDATA}), 64'(0));
    chk("rst_mid_rdata", 64'(rsp_rdata), 64'(0));
    repeat (2) @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    for (int k = 0; k < N; k++) exp_q[k].delete();
    rc0 = rsp_count;
    grant_log.delete();
    for (int i = 0; i < N; i++) issue(i, 1'b1, AW'((i << 8) | 'h40), $urandom);
    drain("drain_post_reset");
    chk("post_reset_first", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'(0));
    chk("post_reset_pulses", 64'(rsp_count - rc0), 64'(N));

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Round-robin APB master that shares one APB completer, such as the dual-port memory slave, between NUM_REQ requesters.
- Each requester uses a simple valid/ready request channel and receives a one-cycle response pulse.
- The block serialises requests into standard APB SETUP/ACCESS transfers and waits on PREADY, with a timeout guard.
- It sits between bus-side clients (CPU shim, DMA, test loaders) and the APB completer.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 32, PADDR and req_addr width per requester.
- DATA_WIDTH, 32, PWDATA/PRDATA/req_wdata/rsp_rdata width.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles without PREADY before abort (>=2).

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit set.
- req_write  in  NUM_REQ  1=write, 0=read, per requester.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data, same packing.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- rsp_rdata  out  DATA_WIDTH  shared read data; valid only with rsp_valid.
- rsp_err  out  1  timeout flag; valid only with rsp_valid.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.
- busy  out  1  high in SETUP and ACCESS.

Behaviour:
- Reset (async, PRESETn=0):
  - State IDLE; rr pointer 0; wait counter 0.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, busy all 0.
  - Reset mid-transfer aborts silently; no rsp_valid is issued for the aborted request.
- FSM states are IDLE, SETUP and ACCESS.
- IDLE:
  - Grant g = first index i with req_valid[i]=1, searching ptr, ptr+1, ... mod NUM_REQ.
  - req_ready[g]=1 combinationally, only in IDLE; all bits 0 in every other state.
  - On accept (valid&ready): register PADDR, PWDATA and PWRITE from requester g, and register owner=g.
  - Assert PSEL=1, PENABLE=0 and move to SETUP.
  - No valid requests: stay in IDLE with PSEL=0 and PENABLE=0.
- SETUP: exactly one cycle. Next state ACCESS with PENABLE=1, PSEL held at 1.
- ACCESS:
  - PADDR, PWRITE and PWDATA are held stable from SETUP until the transfer ends.
  - PREADY is sampled only in ACCESS and ignored in IDLE/SETUP.
  - PREADY=1: drop PSEL and PENABLE, then go to IDLE.
    - Next cycle: rsp_valid[owner]=1; rsp_err=0.
    - rsp_rdata = PRDATA captured at that edge for reads, 0 for writes.
    - ptr = (owner+1) mod NUM_REQ.
  - Wait counter starts at 0 on ACCESS entry and increments per ACCESS cycle with PREADY=0.
  - Timeout: counter reaches TIMEOUT_CYCLES-1 with PREADY=0.
    - Drop PSEL and PENABLE, then go to IDLE.
    - Next cycle: rsp_valid[owner]=1, rsp_err=1, rsp_rdata=0.
    - ptr advances as on normal completion.
- Response outputs are registered. rsp_valid is a single-cycle pulse; rsp_rdata and rsp_err return to 0 the cycle after.
- Latency:
  - Accept to first ACCESS cycle is 2 cycles.
  - rsp_valid comes 1 cycle after PREADY is sampled.
  - Minimum occupancy per transfer is 4 cycles: IDLE accept, SETUP, ACCESS, IDLE.
  - The response cycle doubles as the next IDLE, so back-to-back grants are allowed.
- A new request from the same requester may be presented in the same cycle as its rsp_valid. It is granted only if round-robin order allows.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 other transfers.
- Requesters must hold req_valid, req_write, req_addr and req_wdata stable until accepted. The block does not check this.
- busy=1 exactly when state is SETUP or ACCESS.

Test Plan:
- Single write, then read: req 0 writes addr 0x10 data 0xDEADBEEF, then reads 0x10.
  - Write: PSEL/PENABLE follow SETUP then ACCESS.
  - Write: rsp_valid[0] 1 cycle after PREADY, rsp_err=0.
  - Read: rsp_rdata=0xDEADBEEF.
- Round-robin, all four requesters valid continuously (writes to 0x0, 0x4, 0x8, 0xC, then 0x0 again):
  - Grant order 0,1,2,3,0.
  - PADDR sequence 0x0, 0x4, 0x8, 0xC, 0x0.
  - Exactly one req_ready bit high per accept.
- Pointer wrap: ptr=3 after serving req 2; only reqs 0 and 3 valid -> req 3 granted first, then 0.
- Timeout: completer holds PREADY=0 -> after 16 ACCESS cycles PSEL drops; rsp_valid[owner]=1, rsp_err=1, rsp_rdata=0; next request proceeds normally.
- Wait states: PREADY asserted on the 3rd ACCESS cycle -> PADDR/PWDATA/PWRITE stable throughout, busy=1 for 4 cycles, one rsp_valid pulse.
- Reset mid-ACCESS (PRESETn low for 2 cycles) -> all outputs 0 immediately, no rsp_valid, ptr=0; after release, req 0 is granted first when all are valid.
